// File: rtl/count_seq_ctrl_if.sv
// Control/status bundle between the sequencing master (FSM/CSR logic) and count_seq_ctrl.
// The pause input exists only when CSEQ_PAUSE_EN is defined.
interface count_seq_ctrl_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
);
  logic                  start;
  logic                  stop;
  logic                  auto_reload;
  logic [WIDTH-1:0]      period;
  logic [PRESCALE_W-1:0] prescale;
`ifdef CSEQ_PAUSE_EN
  logic                  pause;
`endif
  logic                  tick_en;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  done;

`ifdef CSEQ_PAUSE_EN
  modport master (output start, stop, auto_reload, period, prescale, pause,
                  input  tick_en, count, busy, done);
  modport slave  (input  start, stop, auto_reload, period, prescale, pause,
                  output tick_en, count, busy, done);
`else
  modport master (output start, stop, auto_reload, period, prescale,
                  input  tick_en, count, busy, done);
  modport slave  (input  start, stop, auto_reload, period, prescale,
                  output tick_en, count, busy, done);
`endif
endinterface

// File: rtl/count_seq_ctrl.sv
// Count sequencer: prescaled tick strobe, period tracking, one-shot or auto-reload.
// Optional pause input enabled by defining CSEQ_PAUSE_EN.
//
// state  | meaning
// IDLE   | waiting for start with nonzero period; count frozen for readback
// ARM    | one busy cycle, prescaler cleared
// RUN    | prescaler running, tick_en strobes, count advances modulo period
// DONE   | one cycle of done after a one-shot round completes
module count_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  count_seq_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  auto_q, auto_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pause_w;
  logic                  tick;
  logic                  terminal;

`ifdef CSEQ_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  // stop and pause both suppress the strobe, so stop always beats a terminal tick
  assign tick     = (state_q == S_RUN) && (psc_cnt_q == prescale_q) && !bus.stop && !pause_w;
  assign terminal = tick && (count_q == (period_q - CNT_ONE));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    psc_cnt_d  = psc_cnt_q;
    prescale_d = prescale_q;
    auto_d     = auto_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start && (bus.period != '0)) begin
          period_d   = bus.period;
          prescale_d = bus.prescale;
          auto_d     = bus.auto_reload;
          count_d    = '0;
          busy_d     = 1'b1;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          psc_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!pause_w) begin
          if (terminal) begin
            psc_cnt_d = '0;
            count_d   = '0;
            done_d    = 1'b1;
            if (!auto_q) begin
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end else if (tick) begin
            psc_cnt_d = '0;
            count_d   = count_q + CNT_ONE;
          end else begin
            psc_cnt_d = psc_cnt_q + PSC_ONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      period_q   <= '0;
      psc_cnt_q  <= '0;
      prescale_q <= '0;
      auto_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      psc_cnt_q  <= psc_cnt_d;
      prescale_q <= prescale_d;
      auto_q     <= auto_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tick_en = tick;
  assign bus.count   = count_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: directed scenarios plus random traffic against
// a cycle-count model (ticks = effective RUN cycles / (prescale+1)). Honours CSEQ_PAUSE_EN.
module tb_count_seq_ctrl;
  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 8;
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DONE = 3;

  logic clk;
  logic rst;
  logic pause;
  int   total = 0;
  int   bad   = 0;

  count_seq_ctrl_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  count_seq_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef CSEQ_PAUSE_EN
  assign bus.pause = pause;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: phase, latched config, effective RUN cycles since ARM, frozen idle count
  int m_phase, m_per, m_psc, m_auto, m_run, m_hold, m_done;
  int e_tick, e_count;

  function automatic int exp_count();
    if (m_phase == P_ARM || m_phase == P_RUN) return (m_run / (m_psc + 1)) % m_per;
    if (m_phase == P_DONE) return 0;
    return m_hold;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    int pz;
    @(negedge clk);
    pz = 0;
`ifdef CSEQ_PAUSE_EN
    pz = int'(pause);
`endif
    e_tick  = (m_phase == P_RUN && !bus.stop && pz == 0 &&
               ((m_run + 1) % (m_psc + 1)) == 0) ? 1 : 0;
    e_count = exp_count();
    chk("tick_en", 32'(bus.tick_en), 32'(e_tick));
    chk("count",   32'(bus.count),   32'(e_count));
    chk("busy",    32'(bus.busy),    32'((m_phase == P_ARM || m_phase == P_RUN) ? 1 : 0));
    chk("done",    32'(bus.done),    32'(m_done));
    @(posedge clk);
    if (rst) begin
      m_phase = P_IDLE; m_hold = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_phase)
        P_IDLE: if (bus.start && bus.period != 0) begin
          m_per = int'(bus.period); m_psc = int'(bus.prescale); m_auto = int'(bus.auto_reload);
          m_run = 0; m_hold = 0; m_phase = P_ARM;
        end
        P_ARM: begin
          if (bus.stop) begin m_hold = 0; m_phase = P_IDLE; end
          else begin m_run = 0; m_phase = P_RUN; end
        end
        P_RUN: begin
          if (bus.stop) begin
            m_hold = e_count; m_phase = P_IDLE;
          end else if (pz == 0) begin
            if (e_tick == 1 && (((m_run + 1) / (m_psc + 1)) % m_per) == 0) begin
              m_done = 1;
              if (m_auto == 0) m_phase = P_DONE;
            end
            m_run++;
          end
        end
        default: begin m_hold = 0; m_phase = P_IDLE; end
      endcase
    end
    #1;
  endtask

  task automatic cfg(input int per, input int psc, input int au);
    bus.period = WIDTH'(per); bus.prescale = PRESCALE_W'(psc); bus.auto_reload = au[0];
  endtask

  task automatic kick();
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; pause = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; cfg(0, 0, 0);
    m_phase = P_IDLE; m_per = 1; m_psc = 0; m_auto = 0; m_run = 0; m_hold = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    // reset held with random inputs
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'($urandom); bus.stop = 1'($urandom); cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      step();
    end
    rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    step();

    // one-shot, period 5, no prescale
    cfg(5, 0, 0); kick();
    repeat (9) step();

    // one-shot, period 3, prescale 2; inputs change after start and must not matter
    cfg(3, 2, 0); kick(); cfg(9, 7, 1);
    repeat (14) step();

    // auto-reload period 4, then stop at count 2
    cfg(4, 0, 1); kick();
    repeat (10) step();
    guard = 0;
    while (!(m_phase == P_RUN && exp_count() == 2) && guard < 50) begin step(); guard++; end
    chk("wait_count2", 32'(guard < 50), 32'd1);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    repeat (4) step();
    chk("stop_hold", 32'(bus.count), 32'd2);

    // start with period 0 ignored; start while busy ignored
    cfg(0, 0, 0); kick(); repeat (3) step();
    cfg(7, 1, 0); kick(); step();
    cfg(2, 0, 1); kick();
    repeat (20) step();

    // reset in RUN at count 3
    cfg(6, 0, 0); kick();
    guard = 0;
    while (!(m_phase == P_RUN && exp_count() == 3) && guard < 50) begin step(); guard++; end
    chk("wait_count3", 32'(guard < 50), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    repeat (3) step();

    // period 15 max, prescale 0, single-tick period 1 with auto
    cfg(15, 0, 0); kick(); repeat (20) step();
    cfg(1, 0, 1); kick(); repeat (5) step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0; step();

`ifdef CSEQ_PAUSE_EN
    cfg(8, 1, 1); kick(); repeat (5) step();
    pause = 1'b1; repeat (4) step(); pause = 1'b0;
    repeat (6) step();
    pause = 1'b1; bus.stop = 1'b1; step(); bus.stop = 1'b0; pause = 1'b0;
    repeat (2) step();
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      pause     = ($urandom_range(0, 7) == 0);
      cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      step();
    end
    rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; pause = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
